// File: rtl/black_target_locator_if.sv
// black_target_locator_if: binarized pixel stream from the black-threshold stage
interface black_target_locator_if;
  logic bin_vsync;
  logic bin_href;
  logic bin_de;
  logic bin_monoc;
  modport master (output bin_vsync, bin_href, bin_de, bin_monoc);
  modport slave (input bin_vsync, bin_href, bin_de, bin_monoc);
endinterface

// File: rtl/black_target_locator.sv
// black_target_locator: per-frame bounding box, centre and count of dark pixels
module black_target_locator #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int MIN_PIXELS = 64
) (
  input  logic clk,
  input  logic rst,
  black_target_locator_if.slave bin,
  output logic obj_valid,
  output logic obj_found,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic [10:0] x_center,
  output logic [10:0] y_center,
  output logic [19:0] pix_cnt,
  output logic frame_err
);
  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;
  state_t state;
  logic vs_q, de_q;
  logic [10:0] col, row, xmn, xmx, ymn, ymx;
  logic [19:0] acc;
  logic err;
  logic [11:0] xs, ys;
  logic ovr, found;
  // centre sums are 12 bits wide so min+max never wraps; overrun and threshold tests
  always_comb begin
    xs = {1'b0, xmn} + {1'b0, xmx};
    ys = {1'b0, ymn} + {1'b0, ymx};
    ovr = (col == 11'(H_ACTIVE)) || (row == 11'(V_ACTIVE));
    found = acc >= 20'(MIN_PIXELS);
  end
  // edge-detect registers; vs_q resets high so a frame already in progress is skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      vs_q <= bin.bin_vsync;
      de_q <= bin.bin_de;
    end
  end
  // frame FSM: arm on vsync rise, accumulate while active, publish for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      xmn <= '1;
      xmx <= '0;
      ymn <= '1;
      ymx <= '0;
      acc <= '0;
      err <= 1'b0;
      obj_valid <= 1'b0;
      obj_found <= 1'b0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      x_center <= '0;
      y_center <= '0;
      pix_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      obj_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bin.bin_vsync && !vs_q) begin
            state <= ACTIVE;
            col <= '0;
            row <= '0;
            xmn <= '1;
            xmx <= '0;
            ymn <= '1;
            ymx <= '0;
            acc <= '0;
            err <= 1'b0;
          end
        end
        ACTIVE: begin
          if (!bin.bin_vsync) begin
            state <= REPORT;
          end else if (bin.bin_de) begin
            if (ovr) begin
              err <= 1'b1;
            end else begin
              col <= col + 11'd1;
              if (bin.bin_monoc) begin
                acc <= &acc ? acc : acc + 20'd1;
                xmn <= col < xmn ? col : xmn;
                xmx <= col > xmx ? col : xmx;
                ymn <= row < ymn ? row : ymn;
                ymx <= row > ymx ? row : ymx;
              end
            end
          end else if (de_q) begin
            col <= '0;
            row <= row == 11'(V_ACTIVE) ? row : row + 11'd1;
          end
        end
        REPORT: begin
          state <= IDLE;
          obj_valid <= 1'b1;
          obj_found <= found;
          x_min <= found ? xmn : '0;
          x_max <= found ? xmx : '0;
          y_min <= found ? ymn : '0;
          y_max <= found ? ymx : '0;
          x_center <= found ? xs[11:1] : '0;
          y_center <= found ? ys[11:1] : '0;
          pix_cnt <= acc;
          frame_err <= err;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_black_target_locator.sv
// tb_black_target_locator: directed frames on a 16x8 sensor with hand-computed results
module tb_black_target_locator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic obj_valid, obj_found, frame_err;
  logic [10:0] x_min, x_max, y_min, y_max, x_center, y_center;
  logic [19:0] pix_cnt;
  logic dark [0:9][0:16];
  int total = 0;
  int bad = 0;
  black_target_locator_if bif ();
  black_target_locator #(.H_ACTIVE(16), .V_ACTIVE(8), .MIN_PIXELS(4)) dut (
    .clk(clk), .rst(rst), .bin(bif),
    .obj_valid(obj_valid), .obj_found(obj_found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .x_center(x_center), .y_center(y_center),
    .pix_cnt(pix_cnt), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic clear_dark();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 17; c++) dark[r][c] = 1'b0;
  endtask
  task automatic start_frame();
    @(negedge clk);
    bif.bin_vsync = 1'b0;
    repeat (4) @(negedge clk);
    bif.bin_vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic drive_lines(input int first, input int nl, input int w0);
    for (int r = first; r < first + nl; r++) begin
      for (int c = 0; c < (r == 0 ? w0 : 16); c++) begin
        @(negedge clk);
        bif.bin_de = 1'b1;
        bif.bin_href = 1'b1;
        bif.bin_monoc = dark[r][c];
      end
      @(negedge clk);
      bif.bin_de = 1'b0;
      bif.bin_href = 1'b0;
      bif.bin_monoc = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic end_frame(input string tag, input logic exp);
    @(negedge clk);
    bif.bin_vsync = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_c1"}, obj_valid, 0);
    @(negedge clk);
    chk({tag, "_valid_c2"}, obj_valid, exp);
    @(negedge clk);
    chk({tag, "_valid_c3"}, obj_valid, 0);
  endtask
  task automatic chk_out(input string tag, input int f, input int x0, input int x1, input int y0,
                         input int y1, input int xc, input int yc, input int n, input int e);
    chk({tag, "_found"}, obj_found, f);
    chk({tag, "_x_min"}, x_min, x0);
    chk({tag, "_x_max"}, x_max, x1);
    chk({tag, "_y_min"}, y_min, y0);
    chk({tag, "_y_max"}, y_max, y1);
    chk({tag, "_x_center"}, x_center, xc);
    chk({tag, "_y_center"}, y_center, yc);
    chk({tag, "_pix_cnt"}, pix_cnt, n);
    chk({tag, "_frame_err"}, frame_err, e);
  endtask
  task automatic set_block();
    clear_dark();
    for (int r = 2; r <= 4; r++)
      for (int c = 3; c <= 6; c++) dark[r][c] = 1'b1;
  endtask
  initial begin
    bif.bin_vsync = 1'b0;
    bif.bin_href = 1'b0;
    bif.bin_de = 1'b0;
    bif.bin_monoc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", obj_valid, 0);
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_block();
    start_frame();
    drive_lines(0, 8, 16);
    end_frame("block", 1'b1);
    chk_out("block", 1, 3, 6, 2, 4, 4, 3, 12, 0);
    clear_dark();
    dark[1][5] = 1'b1;
    dark[1][6] = 1'b1;
    dark[5][0] = 1'b1;
    start_frame();
    drive_lines(0, 8, 16);
    end_frame("below", 1'b1);
    chk_out("below", 0, 0, 0, 0, 0, 0, 0, 3, 0);
    clear_dark();
    for (int c = 0; c < 4; c++) dark[0][c] = 1'b1;
    dark[0][16] = 1'b1;
    start_frame();
    drive_lines(0, 8, 17);
    end_frame("overrun", 1'b1);
    chk_out("overrun", 1, 0, 3, 0, 0, 1, 0, 4, 1);
    set_block();
    @(negedge clk);
    rst = 1'b1;
    bif.bin_vsync = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_lines(0, 8, 16);
    end_frame("midstart", 1'b0);
    chk_out("midstart", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    start_frame();
    drive_lines(0, 8, 16);
    end_frame("after_mid", 1'b1);
    chk_out("after_mid", 1, 3, 6, 2, 4, 4, 3, 12, 0);
    clear_dark();
    for (int c = 0; c < 16; c++) dark[0][c] = 1'b1;
    for (int c = 0; c < 16; c++) dark[1][c] = 1'b1;
    start_frame();
    drive_lines(0, 2, 16);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_lines(2, 6, 16);
    end_frame("rst_mid_end", 1'b0);
    clear_dark();
    for (int c = 10; c <= 13; c++) dark[6][c] = 1'b1;
    start_frame();
    drive_lines(0, 8, 16);
    end_frame("after_rst", 1'b1);
    chk_out("after_rst", 1, 10, 13, 6, 6, 11, 6, 4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
